// File: rtl/interrupt_sequencer.sv
// -----------------------------------------------------------------------------
// interrupt_sequencer
//
// Vectored interrupt controller for the ATmega32A core (Timer0/Timer1 sources).
// When an enabled, unmasked timer flag is pending and SREG.I is set, it freezes
// fetch and waits for the next instruction boundary. It then pushes the 14-bit
// return PC onto the stack, low byte first, through the memory-map write path.
// Finally it loads the PC with the vector of the highest-priority source and
// asks the core to clear that source's TIFR flag and SREG.I.
//
// Ports
//   clk              system clock
//   reset_n          asynchronous active-low reset
//   tifr, timsk      joint Timer0/Timer1 flag and mask registers
//   sreg_i           SREG bit 7, global interrupt enable
//   insn_boundary    one-cycle pulse: instruction done, program_counter = next PC
//   program_counter  current PC (word address)
//   sp               current stack pointer
//   hold             freezes fetch / PC increment while a dispatch is in progress
//   busy             sequencer is not idle
//   mm_we            memory-map write strobe
//   mm_addr          memory-map write address
//   mm_wdata         memory-map write data
//   sp_dec           one-cycle request to decrement SP by one
//   pc_overwrite     one-cycle PC load strobe
//   pc_new           vector address loaded with pc_overwrite
//   flag_clear       one-hot TIFR bit-clear pulse
//   i_clear          one-cycle request to clear SREG.I
//
// All outputs are flops updated together with the state register. No input
// reaches an output combinationally.
// -----------------------------------------------------------------------------
module interrupt_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  tifr,
  input  logic [7:0]  timsk,
  input  logic        sreg_i,
  input  logic        insn_boundary,
  input  logic [13:0] program_counter,
  input  logic [15:0] sp,
  output logic        hold,
  output logic        busy,
  output logic        mm_we,
  output logic [15:0] mm_addr,
  output logic [7:0]  mm_wdata,
  output logic        sp_dec,
  output logic        pc_overwrite,
  output logic [13:0] pc_new,
  output logic [7:0]  flag_clear,
  output logic        i_clear
);

  // Vector word addresses, listed from highest to lowest priority.
  localparam logic [13:0] VEC_OCF1A = 14'h00E;
  localparam logic [13:0] VEC_TOV1  = 14'h012;
  localparam logic [13:0] VEC_OCF0  = 14'h014;
  localparam logic [13:0] VEC_TOV0  = 14'h016;

  // Only the four timer sources handled here take part in dispatch.
  localparam logic [7:0]  SRC_MASK  = 8'h17;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_PUSH_L,
    S_PUSH_H,
    S_JUMP
  } state_t;

  typedef enum logic [1:0] {
    SRC_OCF1A,
    SRC_TOV1,
    SRC_OCF0,
    SRC_TOV0
  } src_t;

  state_t      state;
  logic [13:0] ret_pc;
  logic [15:0] sp_q;
  src_t        src_q;

  logic [7:0]  active;
  logic        pending;
  src_t        sel_src;

  // Fixed-priority encode: bit 4, then 2, then 1, then 0. It is only consulted
  // when at least one of those bits is set, so TOV0 is the fall-through case.
  function automatic src_t prio_encode(input logic [7:0] act);
    if (act[4])      return SRC_OCF1A;
    else if (act[2]) return SRC_TOV1;
    else if (act[1]) return SRC_OCF0;
    else             return SRC_TOV0;
  endfunction

  function automatic logic [13:0] vector_of(input src_t s);
    case (s)
      SRC_OCF1A: return VEC_OCF1A;
      SRC_TOV1:  return VEC_TOV1;
      SRC_OCF0:  return VEC_OCF0;
      default:   return VEC_TOV0;
    endcase
  endfunction

  function automatic logic [7:0] flag_of(input src_t s);
    case (s)
      SRC_OCF1A: return 8'h10;
      SRC_TOV1:  return 8'h04;
      SRC_OCF0:  return 8'h02;
      default:   return 8'h01;
    endcase
  endfunction

  assign active  = tifr & timsk & SRC_MASK;
  assign pending = sreg_i & (|active);
  assign sel_src = prio_encode(active);

  // Each transition loads the output flops with the values the new state
  // presents. The strobes and buses therefore default to zero every cycle,
  // and only hold/busy persist across states.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      ret_pc       <= '0;
      sp_q         <= '0;
      src_q        <= SRC_OCF1A;
      hold         <= 1'b0;
      busy         <= 1'b0;
      mm_we        <= 1'b0;
      mm_addr      <= '0;
      mm_wdata     <= '0;
      sp_dec       <= 1'b0;
      pc_overwrite <= 1'b0;
      pc_new       <= '0;
      flag_clear   <= '0;
      i_clear      <= 1'b0;
    end else begin
      mm_we        <= 1'b0;
      mm_addr      <= '0;
      mm_wdata     <= '0;
      sp_dec       <= 1'b0;
      pc_overwrite <= 1'b0;
      pc_new       <= '0;
      flag_clear   <= '0;
      i_clear      <= 1'b0;

      case (state)
        S_IDLE: begin
          // A boundary arriving in this same cycle is deliberately ignored.
          // The return address is only taken from a boundary seen in WAIT.
          if (pending) begin
            state <= S_WAIT;
            hold  <= 1'b1;
            busy  <= 1'b1;
          end
        end

        S_WAIT: begin
          if (!pending) begin
            state <= S_IDLE;
            hold  <= 1'b0;
            busy  <= 1'b0;
          end else if (insn_boundary) begin
            // The source is chosen here, not on entry to WAIT. A higher
            // priority flag that rose while waiting still wins.
            ret_pc   <= program_counter;
            sp_q     <= sp;
            src_q    <= sel_src;
            state    <= S_PUSH_L;
            mm_we    <= 1'b1;
            mm_addr  <= sp;
            mm_wdata <= program_counter[7:0];
            sp_dec   <= 1'b1;
          end
        end

        S_PUSH_L: begin
          // Address comes from the latched SP. The push is then independent of
          // when the core applies the sp_dec update. Wraps 0x0000 -> 0xFFFF.
          state    <= S_PUSH_H;
          mm_we    <= 1'b1;
          mm_addr  <= sp_q - 16'd1;
          mm_wdata <= {2'b00, ret_pc[13:8]};
          sp_dec   <= 1'b1;
        end

        S_PUSH_H: begin
          state        <= S_JUMP;
          pc_overwrite <= 1'b1;
          pc_new       <= vector_of(src_q);
          flag_clear   <= flag_of(src_q);
          i_clear      <= 1'b1;
        end

        S_JUMP: begin
          // The core applies flag_clear/i_clear on this edge. The IDLE cycle
          // that follows therefore sees the serviced request already gone.
          state <= S_IDLE;
          hold  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          hold  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
